// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between the fetch port
// and the load/store port. Data wins by default; a starvation counter forces a
// fetch grant after MAX_STARVE consecutive fetch losses. Read ownership rides
// a READ_LATENCY-deep tag pipeline so each response returns to its issuer.
module unified_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_STARVE   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_resp_valid,
    output logic [DATA_WIDTH-1:0] if_resp_data,
    input  logic                  d_req_valid,
    input  logic                  d_req_we,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam int RL = READ_LATENCY;

    logic [SW-1:0] starve_q, starve_d;
    logic [RL-1:0] vld_q, vld_d;   // tag valid per stage
    logic [RL-1:0] own_q, own_d;   // tag owner per stage: 0 = fetch, 1 = data

    logic starve_hit;
    logic if_gnt, d_gnt, rd_gnt;

    // Arbitration: data first unless fetch has lost MAX_STARVE times in a row;
    // nothing is granted while reset is held.
    always_comb begin
        starve_hit = (starve_q == SW'(MAX_STARVE));
        if_gnt     = ~rst & if_req_valid & (~d_req_valid | starve_hit);
        d_gnt      = ~rst & d_req_valid & ~if_gnt;
        rd_gnt     = if_gnt | (d_gnt & ~d_req_we);
    end

    // Memory command mux from the granted port; idle cycles drive zeros.
    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_req_addr;
        end else if (d_gnt) begin
            mem_we    = d_req_we;
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
        end
    end

    // Starvation counter next state: count fetch losses, saturate, clear on
    // a fetch grant or when fetch is not requesting.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_valid || if_gnt)
            starve_d = '0;
        else if (!starve_hit)
            starve_d = starve_q + SW'(1);
    end

    // Tag pipeline next state: stage 0 takes this cycle's read grant, the
    // rest shift unconditionally (the memory cannot be back-pressured).
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = rd_gnt;
        own_d[0] = d_gnt;
        for (int i = 1; i < RL; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    // State registers; reset flushes in-flight tags so no stale response escapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            vld_q    <= '0;
            own_q    <= '0;
        end else begin
            starve_q <= starve_d;
            vld_q    <= vld_d;
            own_q    <= own_d;
        end
    end

    // Handshake, stall and response routing from the last tag stage.
    always_comb begin
        if_req_ready  = if_gnt;
        d_req_ready   = d_gnt;
        stall         = ~rst & ((if_req_valid & ~if_gnt) | (d_req_valid & ~d_gnt));
        if_resp_valid = vld_q[RL-1] & ~own_q[RL-1];
        d_resp_valid  = vld_q[RL-1] &  own_q[RL-1];
        if_resp_data  = mem_rdata;
        d_resp_data   = mem_rdata;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: three instances (READ_LATENCY 1, 2, 3) share
// stimulus; each has its own read-latency pipe over a common memory model.
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_v, d_v, d_we;
    logic [31:0] if_a, d_a, d_wd;

    // index k is the instance with READ_LATENCY = k+1
    logic        if_rdy [3];
    logic        if_rv  [3];
    logic [31:0] if_rd  [3];
    logic        d_rdy  [3];
    logic        d_rv   [3];
    logic [31:0] d_rd   [3];
    logic        men    [3];
    logic        mwe    [3];
    logic [31:0] maddr  [3];
    logic [31:0] mwd    [3];
    logic [31:0] mrd    [3];
    logic        stl    [3];

    logic [31:0] mem [0:63];

    // memory model: preloaded with i+100 while reset is held, written by instance 0
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i + 100);
        end else if (men[0] && mwe[0]) begin
            mem[maddr[0][5:0]] <= mwd[0];
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g
        logic [31:0] pipe [0:k];
        always @(posedge clk) begin
            pipe[0] <= mem[maddr[k][5:0]];
            for (int i = 1; i <= k; i++) pipe[i] <= pipe[i-1];
        end
        assign mrd[k] = pipe[k];

        unified_mem_arbiter #(.READ_LATENCY(k + 1), .MAX_STARVE(3)) dut (
            .clk(clk), .rst(rst),
            .if_req_valid(if_v), .if_req_addr(if_a), .if_req_ready(if_rdy[k]),
            .if_resp_valid(if_rv[k]), .if_resp_data(if_rd[k]),
            .d_req_valid(d_v), .d_req_we(d_we), .d_req_addr(d_a), .d_req_wdata(d_wd),
            .d_req_ready(d_rdy[k]), .d_resp_valid(d_rv[k]), .d_resp_data(d_rd[k]),
            .mem_en(men[k]), .mem_we(mwe[k]), .mem_addr(maddr[k]), .mem_wdata(mwd[k]),
            .mem_rdata(mrd[k]), .stall(stl[k])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        if_v = iv; if_a = ia; d_v = dv; d_we = dwe; d_a = da; d_wd = dwd;
    endtask

    typedef struct {
        logic        iv;  logic [31:0] ia;
        logic        dv;  logic dwe; logic [31:0] da; logic [31:0] dwd;
        logic        e_ir; logic e_dr; logic e_st; logic e_en; logic e_we;
        logic [31:0] e_ad; logic [31:0] e_wd;
        logic        e_irv; logic [31:0] e_ird;
        logic        e_drv; logic [31:0] e_drd;
    } vec_t;

    vec_t v [18];

    initial begin
        // iv ia  dv we da  wd            ir dr st en we ad  wd            irv ird  drv drd
        v[0]  = '{1, 0, 0, 0, 0, 0,            1, 0, 0, 1, 0, 0,  0,            0, 0,   0, 0};
        v[1]  = '{1, 1, 0, 0, 0, 0,            1, 0, 0, 1, 0, 1,  0,            1, 100, 0, 0};
        v[2]  = '{1, 2, 0, 0, 0, 0,            1, 0, 0, 1, 0, 2,  0,            1, 101, 0, 0};
        v[3]  = '{1, 5, 1, 0, 9, 0,            0, 1, 1, 1, 0, 9,  0,            1, 102, 0, 0};
        v[4]  = '{1, 5, 0, 0, 0, 0,            1, 0, 0, 1, 0, 5,  0,            0, 0,   1, 109};
        v[5]  = '{0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  0,            1, 105, 0, 0};
        v[6]  = '{0, 0, 1, 1, 20, 32'hDEADBEEF, 0, 1, 0, 1, 1, 20, 32'hDEADBEEF, 0, 0,   0, 0};
        v[7]  = '{0, 0, 1, 0, 20, 0,           0, 1, 0, 1, 0, 20, 0,            0, 0,   0, 0};
        v[8]  = '{0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  0,            0, 0,   1, 32'hDEADBEEF};
        // starvation: fetch and loads continuously valid -> D,D,D,F,D,D,D,F
        v[9]  = '{1, 3, 1, 0, 10, 0,           0, 1, 1, 1, 0, 10, 0,            0, 0,   0, 0};
        v[10] = '{1, 3, 1, 0, 11, 0,           0, 1, 1, 1, 0, 11, 0,            0, 0,   1, 110};
        v[11] = '{1, 3, 1, 0, 12, 0,           0, 1, 1, 1, 0, 12, 0,            0, 0,   1, 111};
        v[12] = '{1, 3, 1, 0, 13, 0,           1, 0, 1, 1, 0, 3,  0,            0, 0,   1, 112};
        v[13] = '{1, 3, 1, 0, 14, 0,           0, 1, 1, 1, 0, 14, 0,            1, 103, 0, 0};
        v[14] = '{1, 3, 1, 0, 15, 0,           0, 1, 1, 1, 0, 15, 0,            0, 0,   1, 114};
        v[15] = '{1, 3, 1, 0, 16, 0,           0, 1, 1, 1, 0, 16, 0,            0, 0,   1, 115};
        v[16] = '{1, 3, 1, 0, 17, 0,           1, 0, 1, 1, 0, 3,  0,            0, 0,   1, 116};
        v[17] = '{0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,  0,            1, 103, 0, 0};

        // reset state with both ports requesting: everything must stay quiet
        drive(1, 4, 1, 1, 33, 32'h55);
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d if_ready", k), 32'(if_rdy[k]), 0);
            chk($sformatf("rst%0d d_ready", k),  32'(d_rdy[k]), 0);
            chk($sformatf("rst%0d stall", k),    32'(stl[k]), 0);
            chk($sformatf("rst%0d mem_en", k),   32'(men[k]), 0);
            chk($sformatf("rst%0d mem_addr", k), maddr[k], 0);
            chk($sformatf("rst%0d resp", k),     32'({if_rv[k], d_rv[k]}), 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        #28 rst = 1'b0;

        // table-driven vectors on the READ_LATENCY=1 instance
        for (int r = 0; r < 18; r++) begin
            @(posedge clk); #1;
            drive(v[r].iv, v[r].ia, v[r].dv, v[r].dwe, v[r].da, v[r].dwd);
            #1;
            chk($sformatf("v%0d if_ready", r),  32'(if_rdy[0]), 32'(v[r].e_ir));
            chk($sformatf("v%0d d_ready", r),   32'(d_rdy[0]),  32'(v[r].e_dr));
            chk($sformatf("v%0d stall", r),     32'(stl[0]),    32'(v[r].e_st));
            chk($sformatf("v%0d mem_en", r),    32'(men[0]),    32'(v[r].e_en));
            chk($sformatf("v%0d mem_we", r),    32'(mwe[0]),    32'(v[r].e_we));
            chk($sformatf("v%0d mem_addr", r),  maddr[0],       v[r].e_ad);
            chk($sformatf("v%0d mem_wdata", r), mwd[0],         v[r].e_wd);
            chk($sformatf("v%0d if_rvalid", r), 32'(if_rv[0]),  32'(v[r].e_irv));
            chk($sformatf("v%0d d_rvalid", r),  32'(d_rv[0]),   32'(v[r].e_drv));
            if (v[r].e_irv) chk($sformatf("v%0d if_rdata", r), if_rd[0], v[r].e_ird);
            if (v[r].e_drv) chk($sformatf("v%0d d_rdata", r),  d_rd[0],  v[r].e_drd);
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);

        // READ_LATENCY=3: F(1), D(2), F(3) back to back, responses 3 cycles later
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            case (c)
                0:       drive(1, 1, 0, 0, 0, 0);
                1:       drive(0, 0, 1, 0, 2, 0);
                2:       drive(1, 3, 0, 0, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0);
            endcase
            #1;
            if (c == 0) chk("rl3 grant F1", 32'(if_rdy[2]), 1);
            if (c == 1) chk("rl3 grant D2", 32'(d_rdy[2]), 1);
            if (c == 2) chk("rl3 grant F3", 32'(if_rdy[2]), 1);
            chk($sformatf("rl3 c%0d if_rvalid", c), 32'(if_rv[2]), (c == 3 || c == 5) ? 1 : 0);
            chk($sformatf("rl3 c%0d d_rvalid", c),  32'(d_rv[2]),  (c == 4) ? 1 : 0);
            if (c == 3) chk("rl3 if_rdata 1", if_rd[2], 101);
            if (c == 4) chk("rl3 d_rdata 2",  d_rd[2],  102);
            if (c == 5) chk("rl3 if_rdata 3", if_rd[2], 103);
        end

        // READ_LATENCY=2: fetch granted, reset pulsed mid-flight one cycle later
        @(posedge clk); #1;
        drive(1, 7, 0, 0, 0, 0);
        #1 chk("rl2 pre-reset grant", 32'(if_rdy[1]), 1);
        @(posedge clk); #1;
        drive(1, 8, 1, 0, 4, 0);
        #1 rst = 1'b1;
        #1;
        chk("rl2 async if_ready",  32'(if_rdy[1]), 0);
        chk("rl2 async d_ready",   32'(d_rdy[1]), 0);
        chk("rl2 async stall",     32'(stl[1]), 0);
        chk("rl2 async mem_en",    32'(men[1]), 0);
        chk("rl2 async mem_addr",  maddr[1], 0);
        chk("rl2 async resp",      32'({if_rv[1], d_rv[1]}), 0);
        drive(0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #2;
            chk($sformatf("rl2 flushed c%0d", c), 32'({if_rv[1], d_rv[1]}), 0);
        end
        @(posedge clk); #1;
        drive(1, 9, 0, 0, 0, 0);
        #1 chk("rl2 post-reset grant", 32'(if_rdy[1]), 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("rl2 post-reset wait", 32'(if_rv[1]), 0);
        @(posedge clk); #2;
        chk("rl2 post-reset rvalid", 32'(if_rv[1]), 1);
        chk("rl2 post-reset rdata",  if_rd[1], 109);
        chk("rl2 post-reset d_rv",   32'(d_rv[1]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the data (load/store) port of the CPU datapath.
- Arbitrates each cycle. Data normally wins; a starvation guard periodically forces a fetch grant.
- Tracks in-flight reads through a tag pipeline so each read response is routed back to the port that issued it.
- Drives a stall signal that the PC/pipeline control uses to hold any requester that lost arbitration.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 32, address width (word address, PC-style).
- READ_LATENCY, 1, cycles from read grant to mem_rdata valid; legal range is 1 to 4.
- MAX_STARVE, 3, consecutive fetch losses tolerated before fetch is forced to win; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch read request.
- if_req_addr  in  ADDR_WIDTH  fetch address.
- if_req_ready  out  1  fetch granted this cycle.
- if_resp_valid  out  1  fetch read data valid.
- if_resp_data  out  DATA_WIDTH  fetch read data.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  ADDR_WIDTH  data address.
- d_req_wdata  in  DATA_WIDTH  store data.
- d_req_ready  out  1  data request granted this cycle.
- d_resp_valid  out  1  load data valid; stores produce no response.
- d_resp_data  out  DATA_WIDTH  load data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  read data, valid READ_LATENCY cycles after a read with mem_en=1 and mem_we=0.
- stall  out  1  (if_req_valid & ~if_req_ready) | (d_req_valid & ~d_req_ready).

Behaviour:
- Grant is combinational in the same cycle. At most one of if_req_ready / d_req_ready is high. A request transfers when valid & ready.
- Priority:
  - Only one port valid: that port is granted.
  - Both valid: data wins, unless starve_cnt == MAX_STARVE, in which case fetch wins.
- starve_cnt (registered, width clog2(MAX_STARVE+1)):
  - Increments, saturating at MAX_STARVE, on a cycle where if_req_valid is high and fetch is not granted.
  - Clears on a fetch grant or whenever if_req_valid is low.
- mem_en = any grant. mem_we, mem_addr and mem_wdata come from the granted port; fetch always drives mem_we=0.
- With no grant, mem_we=0 and mem_addr/mem_wdata are 0.
- Tag pipeline: READ_LATENCY stages of {valid, owner}.
  - Stage 0 is loaded each cycle with {grant & ~mem_we, owner=fetch?0:1}.
  - All stages shift every cycle; there is no backpressure.
- Response routing from the last stage:
  - if_resp_valid = last.valid & owner==0.
  - d_resp_valid = last.valid & owner==1.
  - Both resp_data outputs are driven by mem_rdata unconditionally; consumers qualify with valid.
- Read latency: a read granted in cycle N returns its response in cycle N+READ_LATENCY.
- A back-to-back read every cycle gives one response per cycle, in grant order.
- Stores occupy the memory for the grant cycle only and complete on grant.
- Reset (async, active-high):
  - Clears all tag stages and starve_cnt immediately.
  - Outputs on reset: if_resp_valid=0, d_resp_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_req_ready=0, d_req_ready=0, stall=0.
  - Grants are blocked while rst is high.
  - Reads in flight when reset asserts never produce a response after reset deasserts.
- Simultaneous grant and response: legal every cycle. The new tag enters stage 0 while the last stage drives the response.

Test Plan:
- Reset then fetch-only: if_req_valid=1 at addrs 0,1,2 for 3 cycles (READ_LATENCY=1), memory preloaded mem[i]=i+100 -> if_req_ready=1 each cycle, stall=0, if_resp_valid in cycles 1..3 with data 100,101,102, d_resp_valid stays 0.
- Conflict: fetch addr 5 and load addr 9 both valid for 1 cycle -> d_req_ready=1, if_req_ready=0, stall=1, d_resp_data=mem[9] next cycle. Fetch is granted the following cycle if still valid.
- Starvation guard with MAX_STARVE=3: fetch and loads continuously valid -> grant sequence D,D,D,F,D,D,D,F. starve_cnt reads 0,1,2,3,0,...
- Store then load same address: store addr 20 wdata 0xDEADBEEF granted, next cycle load addr 20 -> mem_we=1 in the store cycle, no d_resp for the store, d_resp_data=0xDEADBEEF one cycle after the load grant.
- READ_LATENCY=3, interleaved reads F(a=1),D(a=2),F(a=3) on consecutive cycles -> responses arrive 3 cycles after each grant, on if/d/if in that order, with correct data per owner.
- Reset mid-flight: READ_LATENCY=2, fetch read granted, rst pulsed asynchronously one cycle later -> all outputs 0 immediately. No if_resp_valid for the flushed read; the first response after reset belongs to the first post-reset grant.
